// File: rtl/lstm_cell_pipe.sv
// Pipelined LSTM cell-state update: c' = f*c + i*g, h = o*hardtanh(c').
// Holds DEPTH cell states, supports valid/ready backpressure and a bulk clear.
module lstm_cell_pipe #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 8,
  parameter int DEPTH  = 64,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AWIDTH-1:0]        in_addr,
  input  logic signed [DWIDTH-1:0] in_i,
  input  logic signed [DWIDTH-1:0] in_f,
  input  logic signed [DWIDTH-1:0] in_g,
  input  logic signed [DWIDTH-1:0] in_o,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AWIDTH-1:0]        out_addr,
  output logic signed [DWIDTH-1:0] out_c,
  output logic signed [DWIDTH-1:0] out_h
);
  localparam logic signed [DWIDTH-1:0]   MAXV    = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic signed [DWIDTH-1:0]   MINV    = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic signed [DWIDTH-1:0]   ONE     = DWIDTH'(1) << FRAC;
  localparam logic signed [DWIDTH-1:0]   NEG_ONE = -ONE;
  localparam logic signed [2*DWIDTH-1:0] P_MAX   = {{(DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [2*DWIDTH-1:0] P_MIN   = {{(DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
  state_t state, state_next;

  logic [AWIDTH-1:0]        clr_idx;
  logic                     a_valid;
  logic [AWIDTH-1:0]        a_addr;
  logic signed [DWIDTH-1:0] a_i, a_f, a_g, a_o;
  logic signed [DWIDTH-1:0] c_mem [DEPTH];
  logic                     stall, accept, advance;
  logic signed [DWIDTH-1:0] c_old, c_new, c_clamp, h_new;

  // Fixed-point product: full width, floor shift by FRAC, saturate to DWIDTH.
  function automatic logic signed [DWIDTH-1:0] mul_q(input logic signed [DWIDTH-1:0] a,
                                                    input logic signed [DWIDTH-1:0] b);
    logic signed [2*DWIDTH-1:0] ax, bx, p;
    ax = {{DWIDTH{a[DWIDTH-1]}}, a};
    bx = {{DWIDTH{b[DWIDTH-1]}}, b};
    p  = (ax * bx) >>> FRAC;
    if (p > P_MAX) return MAXV;
    if (p < P_MIN) return MINV;
    return p[DWIDTH-1:0];
  endfunction

  function automatic logic signed [DWIDTH-1:0] add_sat(input logic signed [DWIDTH-1:0] a,
                                                      input logic signed [DWIDTH-1:0] b);
    logic signed [DWIDTH:0] s;
    s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
    if (s[DWIDTH] != s[DWIDTH-1]) return s[DWIDTH] ? MINV : MAXV;
    return s[DWIDTH-1:0];
  endfunction

  assign stall    = out_valid && !out_ready;
  assign in_ready = (state == RUN) && !stall;
  assign accept   = in_valid && in_ready;
  assign advance  = a_valid && !stall;
  assign busy     = (state != RUN);

  // Stage B: the older beat's write lands on the edge the newer beat enters A,
  // so a plain combinational read always sees the latest c.
  always_comb begin
    c_old = c_mem[a_addr];
    c_new = add_sat(mul_q(a_f, c_old), mul_q(a_i, a_g));
    if (c_new > ONE)          c_clamp = ONE;
    else if (c_new < NEG_ONE) c_clamp = NEG_ONE;
    else                      c_clamp = c_new;
    h_new = mul_q(a_o, c_clamp);
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (clr) state_next = DRAIN;
      DRAIN:   if (!a_valid) state_next = CLEAR;
      CLEAR:   if (clr_idx == AWIDTH'(DEPTH-1)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state     <= RUN;
      clr_idx   <= '0;
      a_valid   <= 1'b0;
      a_addr    <= '0;
      a_i       <= '0;
      a_f       <= '0;
      a_g       <= '0;
      a_o       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_c     <= '0;
      out_h     <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      else                clr_idx <= '0;
      if (!stall) begin
        a_valid   <= accept;
        out_valid <= a_valid;
        if (accept) begin
          a_addr <= in_addr;
          a_i    <= in_i;
          a_f    <= in_f;
          a_g    <= in_g;
          a_o    <= in_o;
        end
        if (a_valid) begin
          out_addr <= a_addr;
          out_c    <= c_new;
          out_h    <= h_new;
        end
      end
    end
  end

  // A is always empty during CLEAR, so the two write sources never collide.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int k = 0; k < DEPTH; k++) c_mem[k] <= '0;
    end else if (advance) begin
      c_mem[a_addr] <= c_new;
    end else if (state == CLEAR) begin
      c_mem[clr_idx] <= '0;
    end
  end
endmodule

// File: tb/tb_lstm_cell_pipe.sv
// Self-checking bench for lstm_cell_pipe: integer reference model plus directed literal checks.
module tb_lstm_cell_pipe;
  localparam int DW = 16;
  localparam int FR = 8;
  localparam int DEPTH = 64;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic clr = 1'b0;
  logic busy;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [AW-1:0] in_addr = '0;
  logic signed [DW-1:0] in_i = '0, in_f = '0, in_g = '0, in_o = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic signed [DW-1:0] out_c, out_h;

  always #5 clk = ~clk;

  lstm_cell_pipe #(.DWIDTH(DW), .FRAC(FR), .DEPTH(DEPTH)) dut (
    .clk(clk), .xrst(xrst), .clr(clr), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_i(in_i), .in_f(in_f), .in_g(in_g), .in_o(in_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_c(out_c), .out_h(out_h)
  );

  typedef struct { int addr; int c; int h; } res_t;

  int n_cmp = 0;
  int n_bad = 0;
  int ref_c [DEPTH];
  res_t exp_q[$];
  int obs_c[$], obs_h[$], obs_a[$];
  res_t r;
  logic prev_stall = 1'b0;
  int held_a, held_c, held_h;
  int stall_cycles = 0;
  int e2c [3] = '{128, 256, 384};
  int e2h [3] = '{128, 256, 256};
  int bc;
  bit rnd_done;

  function automatic int satw(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int mulq(int a, int b);
    int p;
    p = a * b;
    return satw(p >>> FR);
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_accept(int a, int i, int f, int g, int o);
    int c, ht;
    res_t e;
    c = satw(mulq(f, ref_c[a]) + mulq(i, g));
    ht = (c > 256) ? 256 : ((c < -256) ? -256 : c);
    ref_c[a] = c;
    e.addr = a; e.c = c; e.h = mulq(o, ht);
    exp_q.push_back(e);
  endtask

  // Compare process: every handshake checked against the model; held outputs checked during stalls.
  always @(negedge clk) begin
    if (xrst) begin
      if (prev_stall) begin
        check("hold_addr", int'(out_addr), held_a);
        check("hold_c", int'(out_c), held_c);
        check("hold_h", int'(out_h), held_h);
      end
      if (out_valid && !out_ready) begin
        check("in_ready_stall", int'(in_ready), 0);
        stall_cycles++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", int'(out_valid), 0);
        else begin
          r = exp_q.pop_front();
          check("out_addr", int'(out_addr), r.addr);
          check("out_c", int'(out_c), r.c);
          check("out_h", int'(out_h), r.h);
          obs_a.push_back(int'(out_addr));
          obs_c.push_back(int'(out_c));
          obs_h.push_back(int'(out_h));
          $display("beat addr=%0d c=%0d h=%0d", out_addr, out_c, out_h);
        end
      end
      prev_stall = out_valid && !out_ready;
      held_a = int'(out_addr); held_c = int'(out_c); held_h = int'(out_h);
      if (in_valid && in_ready)
        model_accept(int'(in_addr), int'(in_i), int'(in_f), int'(in_g), int'(in_o));
      if (clr)
        for (int k = 0; k < DEPTH; k++) ref_c[k] = 0;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(int a, int i, int f, int g, int o);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_addr = a[AW-1:0];
    in_i = i[DW-1:0]; in_f = f[DW-1:0]; in_g = g[DW-1:0]; in_o = o[DW-1:0];
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        check("send_timeout", t, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic int rnd_val();
    logic signed [DW-1:0] t;
    if ($urandom_range(0, 3) == 0) begin
      t = DW'($urandom());
      return int'(t);
    end
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  initial begin
    for (int k = 0; k < DEPTH; k++) ref_c[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_c", int'(out_c), 0);
    check("rst_busy", int'(busy), 0);
    xrst = 1'b1;
    @(posedge clk); #1;

    // Single beat latency and value
    send(3, 256, 128, 128, 256);
    @(negedge clk);
    check("lat_k1_valid", int'(out_valid), 0);
    @(negedge clk);
    check("lat_k2_valid", int'(out_valid), 1);
    check("t1_c", int'(out_c), 128);
    check("t1_h", int'(out_h), 128);
    check("t1_addr", int'(out_addr), 3);
    wait_idle();

    // Back-to-back same-address accumulation
    obs_c.delete(); obs_h.delete(); obs_a.delete();
    for (int k = 0; k < 3; k++) send(5, 256, 256, 128, 256);
    wait_idle();
    check("t2_count", obs_c.size(), 3);
    for (int k = 0; k < 3 && k < obs_c.size(); k++) begin
      check("t2_c", obs_c[k], e2c[k]);
      check("t2_h", obs_h[k], e2h[k]);
    end

    // Saturation
    obs_c.delete(); obs_h.delete(); obs_a.delete();
    send(10, 32767, 0, 32767, 256);
    send(11, 256, 0, -256, 256);
    wait_idle();
    check("t3_count", obs_c.size(), 2);
    if (obs_c.size() == 2) begin
      check("sat_pos_c", obs_c[0], 32767);
      check("sat_pos_h", obs_h[0], 256);
      check("neg_c", obs_c[1], -256);
      check("neg_h", obs_h[1], -256);
    end

    // Backpressure
    obs_c.delete(); obs_h.delete(); obs_a.delete();
    stall_cycles = 0;
    fork
      for (int k = 0; k < 6; k++) send(7, 256, 256, 1, 256);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_stalled", int'(stall_cycles >= 4), 1);
    check("bp_count", obs_c.size(), 6);
    for (int k = 0; k < obs_c.size(); k++) begin
      check("bp_c", obs_c[k], k + 1);
      check("bp_addr", obs_a[k], 7);
    end

    // Clear with a beat accepted in the same cycle
    send(0, 256, 0, 128, 256);
    send(63, 256, 0, 256, 256);
    wait_idle();
    in_valid = 1'b1; in_addr = 6'd0;
    in_i = 16'sd256; in_f = 16'sd256; in_g = 16'sd128; in_o = 16'sd256;
    clr = 1'b1;
    @(negedge clk);
    check("clr_accept", int'(in_ready), 1);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    bc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      check("busy_in_ready", int'(in_ready), 0);
    end
    check("busy_len_ok", int'(bc >= 65 && bc <= 66), 1);
    wait_idle();
    obs_c.delete(); obs_h.delete(); obs_a.delete();
    send(63, 256, 256, 128, 256);
    send(0, 256, 256, 128, 256);
    wait_idle();
    check("clr_count", obs_c.size(), 2);
    if (obs_c.size() == 2) begin
      check("clr_c63", obs_c[0], 128);
      check("clr_c0", obs_c[1], 128);
    end

    // Reset mid-stream
    send(5, 256, 256, 128, 256);
    send(5, 256, 256, 128, 256);
    xrst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) ref_c[k] = 0;
    #1;
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 xrst = 1'b1;
    @(posedge clk); #1;
    obs_c.delete(); obs_h.delete(); obs_a.delete();
    send(5, 256, 256, 64, 256);
    wait_idle();
    check("rst_count", obs_c.size(), 1);
    if (obs_c.size() == 1) check("rst_c", obs_c[0], 64);

    // Randomized traffic with random backpressure
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send(int'($urandom_range(0, 7)), rnd_val(), rnd_val(), rnd_val(), rnd_val());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
